wb_shared_ram: RTL and testbench

//  Wishbone classic slave: single-port word-addressed shared data RAM. Sits directly

---
 rtl/wb_shared_ram_if.sv | 27 ++
 rtl/wb_shared_ram.sv | 148 ++++++++++++++
 tb/tb_wb_shared_ram.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_shared_ram_if.sv
// Wishbone classic bus bundle between the arbiter (master) and the shared RAM
// (slave).
//   wb_cyc, wb_stb  : cycle valid / strobe from the master
//   wb_we           : 1 = write, 0 = read
//   wb_adr          : 32-bit word address
//   wb_dat_i        : write data, master -> slave
//   wb_dat_o        : read data, slave -> master (0 whenever wb_ack is low)
//   wb_ack          : single-cycle transfer acknowledge
interface wb_shared_ram_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    input  wb_dat_o, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    output wb_dat_o, wb_ack
  );
endinterface

// File: rtl/wb_shared_ram.sv
// Wishbone classic slave wrapping a single-port, word-addressed shared RAM.
// Each accepted request waits WAIT_STATES cycles and is then acked for exactly
// one cycle. Accesses at or beyond DEPTH are still acked (so the bus never
// hangs), their writes are dropped, their read data is 0, and they set a
// sticky flag and bump a saturating error counter.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active low
//   bus      : Wishbone slave side (cyc/stb/we/adr/dat_i in, dat_o/ack out)
//   oor_clr  : one-cycle pulse clearing oor_flag and err_cnt
//   oor_flag : sticky out-of-range indicator
//   err_cnt  : saturating count of out-of-range accesses
module wb_shared_ram #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_STATES = 1,
  parameter int ERR_CW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  wb_shared_ram_if.slave    bus,
  input  logic              oor_clr,
  output logic              oor_flag,
  output logic [ERR_CW-1:0] err_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [31:0]       DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0]        CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [ERR_CW-1:0] ERR_MAX  = '1;

  logic [1:0]        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [31:0]       adr_reg;
  logic [31:0]       dat_reg;
  logic              we_reg;
  logic              oor_reg;       // out-of-range status of the access now in ACK
  logic              oor_flag_reg;
  logic [ERR_CW-1:0] err_cnt_reg;
  logic [31:0]       rd_data_reg;
  logic [31:0]       mem [DEPTH];

  logic        req;
  logic        enter_ack;
  logic [31:0] acc_adr;
  logic [31:0] acc_dat;
  logic        acc_we;
  logic        acc_oor;

  assign req = bus.wb_cyc & bus.wb_stb;

  // With zero wait states the access goes from IDLE straight to ACK, so the
  // live bus values are used in IDLE; otherwise the latched copy is used and
  // later bus changes are ignored.
  assign acc_adr = (state_reg == ST_IDLE) ? bus.wb_adr   : adr_reg;
  assign acc_dat = (state_reg == ST_IDLE) ? bus.wb_dat_i : dat_reg;
  assign acc_we  = (state_reg == ST_IDLE) ? bus.wb_we    : we_reg;
  // Full 32-bit compare: upper address bits never alias into the array.
  assign acc_oor = (acc_adr >= DEPTH_W);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_ack  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_next = ST_ACK;
            enter_ack  = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        // Master withdrawing the request aborts silently: no ack, no write.
        if (!req) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == 4'd0) begin
          state_next = ST_ACK;
          enter_ack  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      adr_reg      <= 32'd0;
      dat_reg      <= 32'd0;
      we_reg       <= 1'b0;
      oor_reg      <= 1'b0;
      oor_flag_reg <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == ST_IDLE && req) begin
        adr_reg <= bus.wb_adr;
        dat_reg <= bus.wb_dat_i;
        we_reg  <= bus.wb_we;
      end
      if (enter_ack) begin
        oor_reg <= acc_oor;
      end
      // Clear wins over an increment landing on the same edge.
      if (oor_clr) begin
        oor_flag_reg <= 1'b0;
        err_cnt_reg  <= '0;
      end else if (enter_ack && acc_oor) begin
        oor_flag_reg <= 1'b1;
        if (err_cnt_reg != ERR_MAX) begin
          err_cnt_reg <= err_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Storage is never reset. The commit edge is the ACK-entry edge; a reset
  // arriving on that same edge drops the write.
  always_ff @(posedge clk) begin
    if (enter_ack && rst) begin
      if (acc_we && !acc_oor) begin
        mem[acc_adr[AW-1:0]] <= acc_dat;
      end
      rd_data_reg <= mem[acc_adr[AW-1:0]];
    end
  end

  assign bus.wb_ack   = (state_reg == ST_ACK);
  // Data is only presented for in-range reads during ACK so downstream
  // muxing in the arbiter can simply OR slave outputs.
  assign bus.wb_dat_o = (state_reg == ST_ACK && !oor_reg && !we_reg) ? rd_data_reg : 32'd0;
  assign oor_flag     = oor_flag_reg;
  assign err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_wb_shared_ram.sv
// Scoreboard bench for wb_shared_ram: three instances with 1, 0 and 3 wait
// states share clock and reset. Expected read data is queued when a request
// is driven and compared when the ack arrives.
module tb_wb_shared_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr  [3];
  logic       flag [3];
  logic [7:0] cnt  [3];

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] dat;
    bit          is_read;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  wb_shared_ram_if bus_a ();
  wb_shared_ram_if bus_b ();
  wb_shared_ram_if bus_c ();

  // index 0: WAIT_STATES=1, index 1: WAIT_STATES=0, index 2: WAIT_STATES=3
  wb_shared_ram #(.DEPTH(1024), .AW(10), .WAIT_STATES(1), .ERR_CW(8)) u_ws1 (
    .clk(clk), .rst(rst), .bus(bus_a.slave),
    .oor_clr(clr[0]), .oor_flag(flag[0]), .err_cnt(cnt[0]));
  wb_shared_ram #(.DEPTH(1024), .AW(10), .WAIT_STATES(0), .ERR_CW(8)) u_ws0 (
    .clk(clk), .rst(rst), .bus(bus_b.slave),
    .oor_clr(clr[1]), .oor_flag(flag[1]), .err_cnt(cnt[1]));
  wb_shared_ram #(.DEPTH(1024), .AW(10), .WAIT_STATES(3), .ERR_CW(8)) u_ws3 (
    .clk(clk), .rst(rst), .bus(bus_c.slave),
    .oor_clr(clr[2]), .oor_flag(flag[2]), .err_cnt(cnt[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic drive(input int d, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] dt);
    case (d)
      0: begin bus_a.wb_cyc = c; bus_a.wb_stb = s; bus_a.wb_we = w; bus_a.wb_adr = a; bus_a.wb_dat_i = dt; end
      1: begin bus_b.wb_cyc = c; bus_b.wb_stb = s; bus_b.wb_we = w; bus_b.wb_adr = a; bus_b.wb_dat_i = dt; end
      default: begin bus_c.wb_cyc = c; bus_c.wb_stb = s; bus_c.wb_we = w; bus_c.wb_adr = a; bus_c.wb_dat_i = dt; end
    endcase
  endtask

  function automatic logic ack_of(input int d);
    case (d)
      0:       return bus_a.wb_ack;
      1:       return bus_b.wb_ack;
      default: return bus_c.wb_ack;
    endcase
  endfunction

  function automatic logic [31:0] dat_of(input int d);
    case (d)
      0:       return bus_a.wb_dat_o;
      1:       return bus_b.wb_dat_o;
      default: return bus_c.wb_dat_o;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one access starting at a negedge. exp_lat counts posedges from
  // drive to the ack being visible; clr_k pulses oor_clr on that posedge
  // (0 = never); hold keeps cyc/stb asserted after the ack.
  task automatic bus_op(input int d, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [31:0] exp_rd,
                        input int exp_lat, input int clr_k, input bit hold);
    exp_t e;
    int   n;
    bit   got;
    e.dat     = exp_rd;
    e.is_read = !we;
    sb_q.push_back(e);
    drive(d, 1'b1, 1'b1, we, adr, dat);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      clr[d] = (n + 1 == clr_k);
      tick();
      clr[d] = 1'b0;
      n++;
      if (ack_of(d)) got = 1'b1;
      else check("dat_o_before_ack", dat_of(d), 32'd0);
    end
    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", 32'(n), 32'(exp_lat));
    e = sb_q.pop_front();
    if (got && e.is_read) check("rd_data", dat_of(d), e.dat);
    $display("[TB] dut%0d %s adr=0x%08h dat=0x%08h lat=%0d ack=%0d", d, we ? "WR" : "RD",
             adr, we ? dat : dat_of(d), n, got);
    if (!hold) begin
      drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      check("ack_single_pulse", 32'(ack_of(d)), 32'd0);
      check("dat_o_after_ack", dat_of(d), 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      clr[d] = 1'b0;
      drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    repeat (3) tick();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check("reset_ack", 32'(ack_of(d)), 32'd0);
      check("reset_dat_o", dat_of(d), 32'd0);
      check("reset_oor_flag", 32'(flag[d]), 32'd0);
      check("reset_err_cnt", 32'(cnt[d]), 32'd0);
    end

    // one wait state: write then read back
    bus_op(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 2, 0, 1'b0);
    bus_op(0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 2, 0, 1'b0);

    // zero wait states
    bus_op(1, 1'b1, 32'd0, 32'h12345678, 32'd0, 1, 0, 1'b0);
    bus_op(1, 1'b0, 32'd0, 32'd0, 32'h12345678, 1, 0, 1'b0);

    // out-of-range handling
    bus_op(0, 1'b1, 32'd0, 32'h0BADF00D, 32'd0, 2, 0, 1'b0);
    check("inrange_no_flag", 32'(flag[0]), 32'd0);
    bus_op(0, 1'b1, 32'd1024, 32'hFFFFFFFF, 32'd0, 2, 0, 1'b0);
    check("oor_flag_set", 32'(flag[0]), 32'd1);
    check("err_cnt_1", 32'(cnt[0]), 32'd1);
    bus_op(0, 1'b0, 32'd0, 32'd0, 32'h0BADF00D, 2, 0, 1'b0);
    bus_op(0, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 2, 0, 1'b0);
    check("err_cnt_2", 32'(cnt[0]), 32'd2);
    bus_op(0, 1'b1, 32'h0000_0405, 32'h11111111, 32'd0, 2, 0, 1'b0);
    check("err_cnt_3", 32'(cnt[0]), 32'd3);
    bus_op(0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 2, 0, 1'b0);

    // abort during WAIT (three wait states)
    bus_op(2, 1'b1, 32'd7, 32'hA5A5A5A5, 32'd0, 4, 0, 1'b0);
    drive(2, 1'b1, 1'b1, 1'b1, 32'd7, 32'h5A5A5A5A);
    tick();
    tick();
    check("abort_no_ack_wait", 32'(ack_of(2)), 32'd0);
    drive(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_ack", 32'(ack_of(2)), 32'd0);
    end
    drive(2, 1'b1, 1'b1, 1'b0, 32'd4096, 32'd0);
    tick();
    tick();
    drive(2, 1'b1, 1'b0, 1'b0, 32'd4096, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_oor_no_ack", 32'(ack_of(2)), 32'd0);
    end
    drive(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("abort_err_cnt", 32'(cnt[2]), 32'd0);
    check("abort_oor_flag", 32'(flag[2]), 32'd0);
    bus_op(2, 1'b0, 32'd7, 32'd0, 32'hA5A5A5A5, 4, 0, 1'b0);

    // back-to-back: request held through ack, next access accepted in IDLE
    bus_op(1, 1'b1, 32'd1, 32'h11110001, 32'd0, 1, 0, 1'b1);
    bus_op(1, 1'b1, 32'd2, 32'h22220002, 32'd0, 2, 0, 1'b0);
    bus_op(1, 1'b0, 32'd1, 32'd0, 32'h11110001, 1, 0, 1'b0);
    bus_op(1, 1'b0, 32'd2, 32'd0, 32'h22220002, 1, 0, 1'b0);

    // clear coinciding with an out-of-range ack entry (posedge 2 for WS=1)
    bus_op(0, 1'b1, 32'd1024, 32'h0, 32'd0, 2, 2, 1'b0);
    check("clr_priority_cnt", 32'(cnt[0]), 32'd0);
    check("clr_priority_flag", 32'(flag[0]), 32'd0);
    bus_op(0, 1'b0, 32'd2000, 32'd0, 32'd0, 2, 0, 1'b0);
    check("after_clr_cnt", 32'(cnt[0]), 32'd1);
    check("after_clr_flag", 32'(flag[0]), 32'd1);

    // saturation on the zero-wait instance
    for (int i = 0; i < 257; i++) begin
      bus_op(1, 1'b0, 32'd1024 + 32'(i), 32'd0, 32'd0, 1, 0, 1'b0);
      if (i == 253) check("err_cnt_254", 32'(cnt[1]), 32'd254);
      if (i == 254) check("err_cnt_255", 32'(cnt[1]), 32'd255);
    end
    check("err_cnt_saturated", 32'(cnt[1]), 32'd255);
    check("sat_flag", 32'(flag[1]), 32'd1);

    // reset on the edge that would commit a write (WS=3: accept + 3 edges)
    drive(2, 1'b1, 1'b1, 1'b1, 32'd7, 32'hDEAD0007);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pre_reset_no_ack", 32'(ack_of(2)), 32'd0);
    end
    rst = 1'b0;
    tick();
    check("mid_reset_ack", 32'(ack_of(2)), 32'd0);
    check("mid_reset_dat_o", dat_of(2), 32'd0);
    check("mid_reset_cnt", 32'(cnt[1]), 32'd0);
    check("mid_reset_flag", 32'(flag[0]), 32'd0);
    rst = 1'b1;
    drive(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_no_ack", 32'(ack_of(2)), 32'd0);
    end
    bus_op(2, 1'b0, 32'd7, 32'd0, 32'hA5A5A5A5, 4, 0, 1'b0);
    bus_op(0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 2, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
